// File: rtl/narrow_wide_bridge.sv
// narrow_wide_bridge: packs narrow ingress words into wide words and serialises wide results into a narrow stream.
// Define NWB_PARTIAL_FLUSH_EN to add the flush port, which closes a partially filled packed word early.
module narrow_wide_bridge #(
  parameter int dataWidth = 32,
  parameter int PACK_LANES = 256,
  parameter int UNPACK_LANES = 24
) (
  input  logic clk,
  input  logic rst,
  input  logic bcast,
`ifdef NWB_PARTIAL_FLUSH_EN
  input  logic flush,
`endif
  input  logic in_valid,
  output logic in_ready,
  input  logic [dataWidth-1:0] in_data,
  output logic wide_valid,
  input  logic wide_ready,
  output logic [dataWidth*PACK_LANES-1:0] wide_data,
  input  logic res_valid,
  output logic res_ready,
  input  logic [dataWidth*UNPACK_LANES-1:0] res_data,
  output logic out_valid,
  input  logic out_ready,
  output logic [dataWidth-1:0] out_data,
  output logic out_last,
  output logic [$clog2(PACK_LANES)-1:0] pack_count
);
  localparam int CW = $clog2(PACK_LANES);
  localparam int IW = UNPACK_LANES > 1 ? $clog2(UNPACK_LANES) : 1;
  logic [PACK_LANES-1:0][dataWidth-1:0] acc, nxt;
  logic [UNPACK_LANES-1:0][dataWidth-1:0] hold;
  logic [CW-1:0] cnt;
  logic [IW-1:0] idx;
  logic busy, bc, last_lane, fl, blocked, in_fire, done;
`ifdef NWB_PARTIAL_FLUSH_EN
  assign fl = flush && cnt != '0;
`else
  assign fl = 1'b0;
`endif
  assign bc = bcast && cnt == '0;
  assign last_lane = cnt == CW'(PACK_LANES - 1);
  assign blocked = wide_valid && !wide_ready;
  // Only a word that would complete the packed word has to wait for the output register.
  assign in_ready = !((bc || last_lane || fl) && blocked);
  assign in_fire = in_valid && in_ready;
  assign done = !blocked && (fl || (in_fire && (bc || last_lane)));
  assign pack_count = cnt;
  // Completed word: collected lanes, the word arriving this cycle in lane cnt, zeros above.
  always_comb begin
    nxt = '0;
    for (int l = 0; l < PACK_LANES; l++)
      nxt[l] = bc ? in_data : (CW'(l) < cnt) ? acc[l] : (CW'(l) == cnt && in_fire) ? in_data : '0;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      acc <= '0;
      cnt <= '0;
      wide_valid <= 1'b0;
      wide_data <= '0;
    end else if (done) begin
      wide_data <= nxt;
      wide_valid <= 1'b1;
      cnt <= '0;
    end else begin
      if (wide_ready) wide_valid <= 1'b0;
      if (in_fire) begin
        acc[cnt] <= in_data;
        cnt <= cnt + 1'b1;
      end
    end
  assign out_valid = busy;
  assign out_last = idx == IW'(UNPACK_LANES - 1);
  assign out_data = hold[idx];
  // Reloading on the last-lane beat keeps the narrow stream gap-free.
  assign res_ready = !busy || (out_ready && out_last);
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      hold <= '0;
      idx <= '0;
      busy <= 1'b0;
    end else if (res_valid && res_ready) begin
      hold <= res_data;
      idx <= '0;
      busy <= 1'b1;
    end else if (busy && out_ready) begin
      idx <= out_last ? '0 : idx + 1'b1;
      busy <= !out_last;
    end
endmodule

// File: tb/tb_narrow_wide_bridge.sv
// tb_narrow_wide_bridge: directed table, corner sequences and random traffic against a queue-level model.
module tb_narrow_wide_bridge;
  localparam int DW = 32, PL = 4, UL = 3;
  logic clk = 0, rst = 1, bcast = 0, in_valid = 0, wide_ready = 0, res_valid = 0, out_ready = 0;
  logic in_ready, wide_valid, res_ready, out_valid, out_last;
  logic [DW-1:0] in_data = 0, out_data;
  logic [DW*PL-1:0] wide_data;
  logic [DW*UL-1:0] res_data = 0;
  logic [1:0] pack_count;
`ifdef NWB_PARTIAL_FLUSH_EN
  logic flush = 0;
`endif
  narrow_wide_bridge #(.dataWidth(DW), .PACK_LANES(PL), .UNPACK_LANES(UL)) dut (
    .clk(clk), .rst(rst), .bcast(bcast),
`ifdef NWB_PARTIAL_FLUSH_EN
    .flush(flush),
`endif
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .wide_valid(wide_valid), .wide_ready(wide_ready), .wide_data(wide_data),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
    .pack_count(pack_count));
  always #5 clk = ~clk;
  int n_chk = 0, n_fail = 0;
  logic [DW-1:0] lanes[$];
  logic [DW-1:0] eq[$];
  logic m_wv = 0;
  logic [DW*PL-1:0] m_wd = 0;
  typedef struct {
    logic b;
    logic [DW*PL-1:0] d;
    logic [DW*PL-1:0] exp;
  } vec_t;
  vec_t vecs[4];
  logic [DW-1:0] exp_d[6];
  logic exp_l[6];

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic model_reset();
    lanes.delete();
    eq.delete();
    m_wv = 0;
    m_wd = '0;
  endtask

  // One clock: check DUT against the model, advance the model, then clock.
  task automatic cycle();
    logic would, blk, fire, comp, bc, fl, rr;
    logic [DW*PL-1:0] w;
    #1;
    bc = lanes.size() == 0 && bcast;
    fl = 0;
`ifdef NWB_PARTIAL_FLUSH_EN
    fl = flush && lanes.size() != 0;
`endif
    would = bc || lanes.size() == PL - 1 || fl;
    blk = m_wv && !wide_ready;
    chk("in_ready", in_ready, !(would && blk));
    chk("wide_valid", wide_valid, m_wv);
    if (m_wv) chk("wide_data", wide_data, m_wd);
    chk("pack_count", pack_count, lanes.size());
    chk("out_valid", out_valid, eq.size() != 0);
    if (eq.size() != 0) begin
      chk("out_data", out_data, eq[0]);
      chk("out_last", out_last, eq.size() == 1);
    end
    rr = eq.size() == 0 || (out_ready && eq.size() == 1);
    chk("res_ready", res_ready, rr);
    fire = in_valid && !(would && blk);
    comp = !blk && (fl || (fire && would));
    if (wide_ready) m_wv = 0;
    if (fire) lanes.push_back(in_data);
    if (comp) begin
      w = '0;
      for (int i = 0; i < PL; i++)
        w[i*DW+:DW] = (bc && fire) ? in_data : (i < lanes.size()) ? lanes[i] : '0;
      m_wd = w;
      m_wv = 1;
      lanes.delete();
    end
    if (eq.size() != 0 && out_ready) void'(eq.pop_front());
    if (res_valid && rr)
      for (int i = 0; i < UL; i++) eq.push_back(res_data[i*DW+:DW]);
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic send(input logic [DW-1:0] d);
    in_valid = 1;
    in_data = d;
    cycle();
    in_valid = 0;
  endtask

  initial begin
    vecs[0] = '{b: 0, d: 128'h00000004_00000003_00000002_00000001, exp: 128'h00000004_00000003_00000002_00000001};
    vecs[1] = '{b: 1, d: 128'h00000000_00000000_00000000_DEADBEEF, exp: {4{32'hDEADBEEF}}};
    vecs[2] = '{b: 0, d: 128'h89ABCDEF_01234567_FFFFFFFF_00000000, exp: 128'h89ABCDEF_01234567_FFFFFFFF_00000000};
    vecs[3] = '{b: 1, d: 128'h00000000_00000000_00000000_5A5A5A5A, exp: {4{32'h5A5A5A5A}}};
    repeat (2) @(negedge clk);
    #1;
    chk("reset in_ready", in_ready, 1);
    chk("reset res_ready", res_ready, 1);
    chk("reset wide_valid", wide_valid, 0);
    chk("reset out_valid", out_valid, 0);
    chk("reset pack_count", pack_count, 0);
    chk("reset wide_data", wide_data, 0);
    @(negedge clk);
    rst = 0;
    model_reset();
    wide_ready = 1;
    // Table: pack and broadcast words with the output always drained.
    for (int v = 0; v < 4; v++) begin
      bcast = vecs[v].b;
      for (int k = 0; k < (vecs[v].b ? 1 : PL); k++) begin
        in_valid = 1;
        in_data = vecs[v].d[k*DW+:DW];
        #1 chk("table in_ready", in_ready, 1);
        cycle();
      end
      in_valid = 0;
      bcast = 0;
      chk("table wide_valid", wide_valid, 1);
      chk("table wide_data", wide_data, vecs[v].exp);
      cycle();
    end
    // bcast raised mid-word is ignored until the counter wraps.
    send(32'h11);
    send(32'h22);
    bcast = 1;
    send(32'h33);
    chk("bcast ignored count", pack_count, 3);
    send(32'h44);
    chk("bcast ignored data", wide_data, 128'h00000044_00000033_00000022_00000011);
    send(32'h55);
    chk("bcast at zero", wide_data, {4{32'h55}});
    bcast = 0;
    cycle();
    // Back-pressure: only the completing word stalls.
    wide_ready = 0;
    for (int k = 1; k <= 7; k++) send(k);
    in_valid = 1;
    in_data = 8;
    #1 chk("stall in_ready", in_ready, 0);
    cycle();
    cycle();
    chk("stall wide_data held", wide_data, 128'h00000004_00000003_00000002_00000001);
    chk("stall count", pack_count, 3);
    wide_ready = 1;
    #1 chk("release in_ready", in_ready, 1);
    cycle();
    in_valid = 0;
    chk("release wide_valid", wide_valid, 1);
    chk("release wide_data", wide_data, 128'h00000008_00000007_00000006_00000005);
    cycle();
    // Egress back-to-back with no bubble.
    exp_d = '{32'hA, 32'hB, 32'hC, 32'hD, 32'hE, 32'hF};
    exp_l = '{0, 0, 1, 0, 0, 1};
    out_ready = 1;
    res_valid = 1;
    res_data = {32'hC, 32'hB, 32'hA};
    cycle();
    res_data = {32'hF, 32'hE, 32'hD};
    for (int i = 0; i < 6; i++) begin
      chk("egress valid", out_valid, 1);
      chk("egress data", out_data, exp_d[i]);
      chk("egress last", out_last, exp_l[i]);
      cycle();
      if (i == 2) res_valid = 0;
    end
    chk("egress idle", out_valid, 0);
    // Asynchronous reset mid-word and mid-result.
    send(32'h91);
    send(32'h92);
    out_ready = 0;
    res_valid = 1;
    res_data = {32'h3, 32'h2, 32'h1};
    cycle();
    res_valid = 0;
    out_ready = 1;
    cycle();
    out_ready = 0;
    rst = 1;
    #1;
    chk("midreset out_valid", out_valid, 0);
    chk("midreset pack_count", pack_count, 0);
    chk("midreset wide_data", wide_data, 0);
    chk("midreset res_ready", res_ready, 1);
    @(negedge clk);
    rst = 0;
    model_reset();
    out_ready = 1;
    for (int k = 0; k < PL; k++) send(32'hA1 + k);
    chk("post reset wide_data", wide_data, 128'h000000A4_000000A3_000000A2_000000A1);
    chk("post reset out_valid", out_valid, 0);
    cycle();
`ifdef NWB_PARTIAL_FLUSH_EN
    send(32'h7);
    send(32'h8);
    flush = 1;
    cycle();
    flush = 0;
    chk("flush wide_data", wide_data, 128'h00000000_00000000_00000008_00000007);
    chk("flush count", pack_count, 0);
    cycle();
`endif
    for (int n = 0; n < 800; n++) begin
      in_valid = $urandom_range(0, 3) != 0;
      in_data = $urandom;
      bcast = $urandom_range(0, 7) == 0;
      wide_ready = $urandom_range(0, 2) != 0;
      res_valid = $urandom_range(0, 1) == 1;
      res_data = {$urandom, $urandom, $urandom};
      out_ready = $urandom_range(0, 3) != 0;
`ifdef NWB_PARTIAL_FLUSH_EN
      flush = $urandom_range(0, 9) == 0;
`endif
      cycle();
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/narrow_wide_bridge.md
# narrow_wide_bridge

Bidirectional width adapter between the host-side narrow data port and the wide on-chip datapaths of the GCN accelerator. Ingress packs a stream of `dataWidth` words into `PACK_LANES`-wide words for the column buffers and weight buffer, with a broadcast mode that replicates one word across all lanes. Egress serialises `UNPACK_LANES`-wide result words from the systolic/activation stage into a narrow stream. Both directions use valid/ready handshakes and sustain one narrow word per cycle.

## Interface
- `dataWidth`, 32, bits per lane/narrow word
- `PACK_LANES`, 256, lanes per packed ingress word (pvadd)
- `UNPACK_LANES`, 24, lanes per egress result word (psys)

- `clk` in 1: single clock, all logic on rising edge
- `rst` in 1: asynchronous, active-high reset
- `bcast` in 1: ingress broadcast mode, sampled only when pack counter is 0
- `in_valid` in 1, `in_ready` out 1, `in_data` in dataWidth: narrow ingress stream
- `wide_valid` out 1, `wide_ready` in 1, `wide_data` out dataWidth*PACK_LANES: packed ingress output
- `res_valid` in 1, `res_ready` out 1, `res_data` in dataWidth*UNPACK_LANES: wide egress input
- `out_valid` out 1, `out_ready` in 1, `out_data` out dataWidth, `out_last` out 1: narrow egress stream
- `pack_count` out $clog2(PACK_LANES): lanes collected in current packed word

## Operation
- Ingress: accumulator `acc` plus output register `wide_data`; counter `cnt` 0..PACK_LANES-1.
- Handshake `in_valid && in_ready` writes `in_data` to lane `cnt` (lane 0 = bits [dataWidth-1:0]), `cnt` increments.
- Completion event: lane PACK_LANES-1 written (pack mode), or any accepted word with `cnt==0 && bcast==1` (all lanes = `in_data`). On completion, `acc` with final lane transferred to `wide_data`, `wide_valid` set, `cnt` returns to 0.
- `in_ready = !(completing_word && wide_valid && !wide_ready)`; non-completing words are always accepted.
- `wide_valid` clears on `wide_ready` unless a new completion occurs the same cycle (then stays 1, data replaced).
- `bcast` changes while `cnt != 0` are ignored until the counter returns to 0.
- Egress: hold register of UNPACK_LANES words, lane index `idx`, flag `busy`.
- `res_ready = !busy || (out_valid && out_ready && out_last)`.
- On `res_valid && res_ready`: load hold register, `idx=0`, `busy=1`.
- `out_data` = lane `idx`; `out_last = (idx == UNPACK_LANES-1)`; `out_valid = busy`.
- On `out_valid && out_ready`: `idx` increments; on last lane `busy` clears unless reloaded the same cycle.
- Ingress and egress are independent; simultaneous activity is allowed.

## Timing
- Reset (asynchronous, any cycle): `cnt=0`, `idx=0`, `busy=0`, `wide_valid=0`, `out_valid=0`, `wide_data=0`, hold register=0, `pack_count=0`. Partial words in flight are discarded. `in_ready=1`, `res_ready=1` combinationally after reset.
- Ingress latency: `wide_valid` rises the cycle after the completing handshake.
- Broadcast mode: one ingress handshake per packed word.
- Egress latency: lane 0 is on `out_data` with `out_valid=1` the cycle after the `res_valid && res_ready` handshake.
- Back-to-back egress: with `out_ready` held at 1, the next wide word loads on the last-lane cycle, giving zero bubbles.
- `out_data`, `out_last`, `out_valid` stay stable while `out_valid && !out_ready`.
- `wide_data` stays stable while `wide_valid && !wide_ready`.

## Configuration
- `NWB_PARTIAL_FLUSH_EN` defined: adds input port `flush` (1 bit).
  - When `flush=1` and `cnt != 0`, the packed word completes immediately: lanes at and above `cnt` are zeroed, transfer rules match a normal completion, and an in-flight word accepted the same cycle lands in lane `cnt` before flushing.
  - `flush` with `cnt == 0` has no effect.
- Not defined: no `flush` port. A packed word completes only on full lane count or on broadcast.

## Test plan
- Reset, PACK_LANES=4, stream 0x1,0x2,0x3,0x4 with `wide_ready=1` -> `wide_data`=0x00000004_00000003_00000002_00000001 one cycle after the 4th handshake; `in_ready` never drops.
- `bcast=1`, send 0xDEADBEEF -> all lanes 0xDEADBEEF one cycle later; toggling `bcast` at `cnt=2` has no effect until `cnt` returns to 0.
- `wide_ready=0` with a word already pending, send 4 more words -> `in_ready` low only on the 4th; releasing `wide_ready` accepts it and the new word appears the following cycle.
- UNPACK_LANES=3, two results {0xA,0xB,0xC},{0xD,0xE,0xF}, `out_ready=1` -> six consecutive outputs A..F, `out_last` on C and F, no bubble.
- Assert `rst` at `cnt=2` and `idx=1` -> next stream starts at lane 0, `out_valid=0`, old partial data never emitted.
- `NWB_PARTIAL_FLUSH_EN`: send 0x7,0x8 then `flush` -> `wide_data` lanes {0x7,0x8,0,0}, `cnt=0`.
